// File: rtl/mem_arbiter_if.sv
// Two-client request/response bus plus the single-port memory strobes the arbiter drives.
// "slave" is the arbiter side; "master" is the clients-plus-memory side.
interface mem_arbiter_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]       resp_err;
    logic             mem_read_en;
    logic [31:0]      mem_read_addr;
    logic [31:0]      mem_read_data;
    logic             mem_write_en;
    logic [31:0]      mem_write_addr;
    logic [31:0]      mem_write_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting two clients access to one memory with a 1-cycle registered read.
// Reads return through a per-client response register two cycles after acceptance.
module mem_arbiter #(
    parameter int unsigned MEM_WORDS = 65536
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    logic [1:0]       in_range;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic             sel;
    logic             acc_any;
    logic             wr_en;
    logic             rd_en;

    logic [1:0]       inflight_q, inflight_d;
    logic [1:0]       oor_q, oor_d;
    logic             last_q, last_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic [1:0][31:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]       resp_err_q, resp_err_d;

    // A read may only be taken when its response slot will be free by capture time.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_client
            assign in_range[gi] = bus.req_addr[gi] < MEM_WORDS;
            assign elig[gi] = !rst && bus.req_valid[gi] &&
                              (bus.req_we[gi] ||
                               (!inflight_q[gi] && (!resp_valid_q[gi] || bus.resp_ready[gi])));
        end
    endgenerate

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    assign sel     = grant[1];
    assign acc_any = |grant;
    assign wr_en   = acc_any &  bus.req_we[sel] & in_range[sel];
    assign rd_en   = acc_any & ~bus.req_we[sel] & in_range[sel];

    assign bus.req_ready      = grant;
    assign bus.mem_write_en   = wr_en;
    assign bus.mem_write_addr = wr_en ? bus.req_addr[sel]  : 32'h0;
    assign bus.mem_write_data = wr_en ? bus.req_wdata[sel] : 32'h0;
    assign bus.mem_read_en    = rd_en;
    assign bus.mem_read_addr  = rd_en ? bus.req_addr[sel]  : 32'h0;

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    always_comb begin
        inflight_d   = grant & ~bus.req_we;
        oor_d        = ~in_range;
        last_d       = acc_any ? grant[1] : last_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        for (int i = 0; i < 2; i++) begin
            // A capture landing on the consume edge keeps the slot valid.
            if (inflight_q[i]) begin
                resp_valid_d[i] = 1'b1;
                resp_rdata_d[i] = oor_q[i] ? 32'h0 : bus.mem_read_data;
                resp_err_d[i]   = oor_q[i];
            end else if (bus.resp_ready[i]) begin
                resp_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= '0;
            oor_q        <= '0;
            last_q       <= 1'b1;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= '0;
        end else begin
            inflight_q   <= inflight_d;
            oor_q        <= oor_d;
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the named scenarios.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter #(.MEM_WORDS(65536)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory stub: registered read, data garbage when no read was issued.
    logic [31:0] store [int unsigned];
    always @(posedge clk) begin
        if (bus.mem_write_en) store[bus.mem_write_addr] = bus.mem_write_data;
        if (bus.mem_read_en)
            bus.mem_read_data <= store.exists(bus.mem_read_addr) ? store[bus.mem_read_addr] : 32'h0;
        else
            bus.mem_read_data <= 32'hBADBAD00;
    end

    // Transaction model: golden contents, scheduled responses, visible response slots.
    typedef struct {
        int          client;
        int          due;
        logic [31:0] data;
        logic        err;
    } sched_t;
    sched_t           sched[$];
    logic [31:0]      golden [int unsigned];
    logic [1:0]       m_valid = '0;
    logic [1:0][31:0] m_data  = '0;
    logic [1:0]       m_err   = '0;
    int               favored = 0;
    int               cyc     = 0;

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : 32'h0;
    endfunction

    always @(negedge clk) begin : compare
        logic [1:0]  elig, exp_ready;
        logic        exp_re, exp_we, oor, busy;
        logic [31:0] exp_ra, exp_wa, exp_wd;
        int          c;
        for (int i = 0; i < 2; i++) begin
            busy = 1'b0;
            foreach (sched[k]) if (sched[k].client == i) busy = 1'b1;
            elig[i] = !rst && bus.req_valid[i] &&
                      (bus.req_we[i] || (!busy && (!m_valid[i] || bus.resp_ready[i])));
        end
        if (elig == 2'b11) exp_ready = (favored == 0) ? 2'b01 : 2'b10;
        else               exp_ready = elig;
        exp_re = 0; exp_we = 0; exp_ra = 0; exp_wa = 0; exp_wd = 0; c = 0; oor = 0;
        if (exp_ready != 2'b00) begin
            c   = exp_ready[1] ? 1 : 0;
            oor = bus.req_addr[c] >= 32'd65536;
            if (bus.req_we[c]) begin
                if (!oor) begin exp_we = 1; exp_wa = bus.req_addr[c]; exp_wd = bus.req_wdata[c]; end
            end else if (!oor) begin
                exp_re = 1; exp_ra = bus.req_addr[c];
            end
        end
        chk("m_req_ready",  {30'h0, bus.req_ready}, {30'h0, exp_ready});
        chk("m_rd_en",      {31'h0, bus.mem_read_en}, {31'h0, exp_re});
        chk("m_rd_addr",    bus.mem_read_addr, exp_ra);
        chk("m_wr_en",      {31'h0, bus.mem_write_en}, {31'h0, exp_we});
        chk("m_wr_addr",    bus.mem_write_addr, exp_wa);
        chk("m_wr_data",    bus.mem_write_data, exp_wd);
        chk("m_resp_valid", {30'h0, bus.resp_valid}, {30'h0, m_valid});
        chk("m_resp_err",   {30'h0, bus.resp_err}, {30'h0, m_err});
        chk("m_rdata0",     bus.resp_rdata[0], m_data[0]);
        chk("m_rdata1",     bus.resp_rdata[1], m_data[1]);
        // Advance model to the next cycle.
        if (rst) begin
            sched.delete();
            m_valid = '0; m_data = '0; m_err = '0; favored = 0;
        end else begin
            for (int i = 0; i < 2; i++) if (m_valid[i] && bus.resp_ready[i]) m_valid[i] = 1'b0;
            for (int k = sched.size() - 1; k >= 0; k--) begin
                if (sched[k].due == cyc + 1) begin
                    m_valid[sched[k].client] = 1'b1;
                    m_data[sched[k].client]  = sched[k].data;
                    m_err[sched[k].client]   = sched[k].err;
                    sched.delete(k);
                end
            end
            if (exp_ready != 2'b00) begin
                favored = 1 - c;
                if (bus.req_we[c]) begin
                    if (!oor) golden[bus.req_addr[c]] = bus.req_wdata[c];
                end else begin
                    sched.push_back('{client: c, due: cyc + 2,
                                      data: oor ? 32'h0 : gold_rd(bus.req_addr[c]), err: oor});
                end
            end
        end
        cyc++;
    end

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        bus.req_valid = v;  bus.req_we = we;
        bus.req_addr[0] = a0; bus.req_addr[1] = a1;
        bus.req_wdata[0] = d0; bus.req_wdata[1] = d1;
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0);
        bus.resp_ready = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", {30'h0, bus.req_ready}, 32'h0);
        chk("rst_resp_valid", {30'h0, bus.resp_valid}, 32'h0);
        next();
        rst = 1'b0;

        // Preload and initial round-robin priority.
        drive(2'b11, 2'b11, 1, 2, 32'h1111_1111, 32'h2222_2222);
        @(negedge clk); chk("pre_grant_c0", {30'h0, bus.req_ready}, 32'h1);
        next(); bus.req_valid = 2'b10;
        @(negedge clk); chk("pre_grant_c1", {30'h0, bus.req_ready}, 32'h2);
        next();

        // Write then read addr 5.
        drive(2'b01, 2'b01, 5, 0, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        chk("raw_wr_en", {31'h0, bus.mem_write_en}, 32'h1);
        chk("raw_wr_addr", bus.mem_write_addr, 32'd5);
        chk("raw_wr_data", bus.mem_write_data, 32'hDEAD_BEEF);
        next(); bus.req_we = 2'b00;
        @(negedge clk); chk("raw_rd_en", {31'h0, bus.mem_read_en}, 32'h1);
        next(); bus.req_valid = 2'b00;
        @(negedge clk); chk("raw_n1_valid", {30'h0, bus.resp_valid}, 32'h0);
        next();
        @(negedge clk);
        chk("raw_n2_valid", {30'h0, bus.resp_valid}, 32'h1);
        chk("raw_n2_data", bus.resp_rdata[0], 32'hDEAD_BEEF);
        chk("raw_n2_err", {30'h0, bus.resp_err}, 32'h0);
        next(); bus.resp_ready = 2'b11;
        next();

        // Both clients stream reads; last grant was client 0, so client 1 leads.
        drive(2'b11, 2'b00, 1, 2, 0, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rr_grant_%0d", k), {30'h0, bus.req_ready}, (k % 2 == 0) ? 32'h2 : 32'h1);
            chk($sformatf("rr_rd_en_%0d", k), {31'h0, bus.mem_read_en}, 32'h1);
            if (k >= 2) begin
                chk($sformatf("rr_valid_%0d", k), {30'h0, bus.resp_valid}, (k % 2 == 0) ? 32'h2 : 32'h1);
                if (k % 2 == 0) chk($sformatf("rr_data1_%0d", k), bus.resp_rdata[1], 32'h2222_2222);
                else            chk($sformatf("rr_data0_%0d", k), bus.resp_rdata[0], 32'h1111_1111);
            end
            next();
        end
        bus.req_valid = 2'b00;
        repeat (3) next();

        // Out-of-range read and write from client 1.
        drive(2'b10, 2'b00, 0, 70000, 0, 0);
        @(negedge clk);
        chk("oor_rd_ready", {30'h0, bus.req_ready}, 32'h2);
        chk("oor_rd_en", {31'h0, bus.mem_read_en}, 32'h0);
        next(); bus.req_valid = 2'b00;
        next();
        @(negedge clk);
        chk("oor_valid", {30'h0, bus.resp_valid}, 32'h2);
        chk("oor_data", bus.resp_rdata[1], 32'h0);
        chk("oor_err", {30'h0, bus.resp_err}, 32'h2);
        next();
        drive(2'b10, 2'b10, 0, 70000, 0, 32'hCAFE_F00D);
        @(negedge clk);
        chk("oor_wr_ready", {30'h0, bus.req_ready}, 32'h2);
        chk("oor_wr_en", {31'h0, bus.mem_write_en}, 32'h0);
        next(); bus.req_valid = 2'b00;
        next();

        // Back-pressure: pending response blocks the next read.
        bus.resp_ready = 2'b00;
        drive(2'b01, 2'b00, 1, 0, 0, 0);
        @(negedge clk); chk("bp_first_ready", {30'h0, bus.req_ready}, 32'h1);
        next(); bus.req_valid = 2'b00;
        next();
        drive(2'b01, 2'b00, 5, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_blocked_%0d", k), {30'h0, bus.req_ready}, 32'h0);
            chk($sformatf("bp_hold_%0d", k), bus.resp_rdata[0], 32'h1111_1111);
            next();
        end
        bus.resp_ready = 2'b01;
        @(negedge clk); chk("bp_release_ready", {30'h0, bus.req_ready}, 32'h1);
        next(); bus.resp_ready = 2'b00; bus.req_valid = 2'b00;
        @(negedge clk); chk("bp_gap_valid", {30'h0, bus.resp_valid}, 32'h0);
        next();
        @(negedge clk);
        chk("bp_second_valid", {30'h0, bus.resp_valid}, 32'h1);
        chk("bp_second_data", bus.resp_rdata[0], 32'hDEAD_BEEF);
        next(); bus.resp_ready = 2'b11;
        next();

        // Reset one cycle after a read acceptance.
        drive(2'b01, 2'b00, 1, 0, 0, 0);
        @(negedge clk); chk("rr_pre_reset_ready", {30'h0, bus.req_ready}, 32'h1);
        next();
        rst = 1'b1;
        drive(2'b11, 2'b11, 9, 10, 32'h1234_5678, 32'h8765_4321);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("mr_ready_%0d", k), {30'h0, bus.req_ready}, 32'h0);
            chk($sformatf("mr_rd_en_%0d", k), {31'h0, bus.mem_read_en}, 32'h0);
            chk($sformatf("mr_wr_en_%0d", k), {31'h0, bus.mem_write_en}, 32'h0);
            chk($sformatf("mr_wr_addr_%0d", k), bus.mem_write_addr, 32'h0);
            chk($sformatf("mr_wr_data_%0d", k), bus.mem_write_data, 32'h0);
            next();
        end
        rst = 1'b0;
        bus.req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mr_no_resp_%0d", k), {30'h0, bus.resp_valid}, 32'h0);
            next();
        end
        drive(2'b11, 2'b11, 7, 8, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
        @(negedge clk); chk("mr_grant_c0", {30'h0, bus.req_ready}, 32'h1);
        next(); bus.req_valid = 2'b10;
        @(negedge clk); chk("mr_grant_c1", {30'h0, bus.req_ready}, 32'h2);
        next(); bus.req_valid = 2'b00;
        repeat (3) next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_WORDS, 65536, number of valid 32-bit words; word index >= MEM_WORDS is out of range.
REQ-002 Ports (client vectors indexed [1:0]; 32-bit client fields packed [1:0][31:0]):
  clk             in   1   single clock, all state on rising edge
  rst             in   1   synchronous, active-high reset
  req_valid       in   2   client request valid
  req_ready       out  2   client request accepted this cycle
  req_we          in   2   1 = write, 0 = read
  req_addr        in   2x32  word index
  req_wdata       in   2x32  write data
  resp_valid      out  2   read response valid
  resp_ready      in   2   client consumes response
  resp_rdata      out  2x32  read data
  resp_err        out  2   response is for an out-of-range read
  mem_read_en     out  1   memory read strobe
  mem_read_addr   out  32  memory read word index
  mem_read_data   in   32  memory read data, registered by memory, valid the cycle after mem_read_en
  mem_write_en    out  1   memory write strobe
  mem_write_addr  out  32  memory write word index
  mem_write_data  out  32  memory write data
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.

Function
REQ-004 At most one request accepted per cycle; accept[i] = req_valid[i] & req_ready[i]; req_ready is one-hot or zero.
REQ-005 Eligibility: write eligible when req_valid & req_we; read eligible when req_valid & !req_we & !inflight[i] & (!resp_valid[i] | resp_ready[i]).
REQ-006 Round-robin: if both eligible, grant the client not granted last; pointer updates only on acceptance; after reset client 0 has priority.
REQ-007 req_ready[i] high only for the granted eligible client; combinational from current inputs and state; req_ready may depend on req_valid.
REQ-008 Accepted in-range write, cycle N: mem_write_en=1, mem_write_addr/data = client addr/wdata, same cycle; no client response.
REQ-009 Accepted out-of-range write: accepted (req_ready=1), mem_write_en stays 0, silently dropped.
REQ-010 Accepted in-range read, cycle N: mem_read_en=1, mem_read_addr = req_addr in N; inflight[i] set for cycle N+1; mem_read_data captured into resp_rdata[i] at end of N+1; resp_valid[i]=1, resp_err[i]=0 from N+2.
REQ-011 Accepted out-of-range read: mem_read_en stays 0; same 2-cycle timing; resp_rdata[i]=0, resp_err[i]=1.
REQ-012 Response held stable until resp_valid & resp_ready; resp_valid cleared next edge unless a new capture for that client lands on the same edge (capture wins).
REQ-013 Max read throughput per client: one read per 2 cycles; the two clients may interleave reads every cycle.
REQ-014 mem_read_en/mem_write_en never both 1; mem_*_addr and mem_write_data = 0 whenever the corresponding strobe is 0.
REQ-015 Read-after-write: a write accepted in N is visible to any read accepted in N+1 or later.

Reset
REQ-016 While rst=1: req_ready=0, mem_read_en=0, mem_write_en=0, mem addr/data outputs=0.
REQ-017 On reset edge: resp_valid=0, resp_rdata=0, resp_err=0, inflight=0, round-robin priority to client 0.
REQ-018 Reset mid-operation: in-flight reads discarded; no resp_valid from pre-reset requests after reset deasserts.

Verification
REQ-019 Client 0 writes addr 5 = 0xDEADBEEF, then reads addr 5 -> mem_write_en pulse at N; resp_valid[0] at read-accept+2, resp_rdata[0]=0xDEADBEEF, resp_err[0]=0.
REQ-020 Both clients hold reads (addr 1, addr 2) continuously, resp_ready=1 -> grants alternate 0,1,0,1; mem_read_en every cycle; each client one response per 2 cycles with correct data.
REQ-021 Client 1 reads addr 70000 (MEM_WORDS=65536) -> mem_read_en stays 0; resp_valid[1] after 2 cycles, resp_rdata=0, resp_err=1; out-of-range write -> mem_write_en stays 0.
REQ-022 Client 0 resp_ready=0 with response pending, second read valid -> req_ready[0]=0 until resp_ready=1; in that cycle req_ready[0]=1, new response arrives 2 cycles later, first data not overwritten before consumption.
REQ-023 rst asserted one cycle after a read acceptance -> all outputs zero during reset; no resp_valid after deassert; next simultaneous request pair grants client 0 first.
